// File: rtl/hps_reset_req_gen.sv
// HPS fabric-to-HPS reset request generator: debounced pushbuttons and soft
// requests become fixed-width active-low pulses, arbitrated cold > warm > debug.
module hps_reset_req_gen #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int PULSE_CYCLES    = 64,
   parameter int HOLDOFF_CYCLES  = 1024,
   parameter int POR_CYCLES      = 4096
) (
   input  logic clk_clk,
   input  logic reset_reset_n,
   input  logic key_cold_n,
   input  logic key_warm_n,
   input  logic key_debug_n,
   input  logic soft_cold_req,
   input  logic soft_warm_req,
   output logic hps_0_f2h_cold_reset_req_reset_n,
   output logic hps_0_f2h_warm_reset_req_reset_n,
   output logic hps_0_f2h_debug_reset_req_reset_n,
   output logic busy,
   output logic dropped
);

   localparam int MAX_AB = (DEBOUNCE_CYCLES > PULSE_CYCLES) ? DEBOUNCE_CYCLES : PULSE_CYCLES;
   localparam int MAX_CD = (HOLDOFF_CYCLES > POR_CYCLES) ? HOLDOFF_CYCLES : POR_CYCLES;
   localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_STARTUP,
      ST_IDLE,
      ST_ASSERT,
      ST_HOLDOFF
   } state_t;

   typedef enum logic [1:0] {
      SEL_COLD,
      SEL_WARM,
      SEL_DEBUG
   } sel_t;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] x);
      return (x == '1) ? x : x + 1'b1;
   endfunction

   // Bit order everywhere below: [0] cold, [1] warm, [2] debug.
   logic [2:0]            keyRaw;
   logic [2:0]            sync1_q, sync2_q;
   logic [2:0]            keyDeb_q, keyDeb_d;
   logic [2:0]            keyEvt_q, keyEvt_d;
   logic [2:0][CNT_W-1:0] debCnt_q, debCnt_d;

   state_t           state_q, state_d;
   sel_t             sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dropped_q, dropped_d;
   logic             coldN_q, coldN_d;
   logic             warmN_q, warmN_d;
   logic             debugN_q, debugN_d;
   logic             busy_q, busy_d;
   logic             reqCold, reqWarm, reqDebug, reqAny;

   assign keyRaw = {key_debug_n, key_warm_n, key_cold_n};

   always_comb begin
      keyDeb_d = keyDeb_q;
      keyEvt_d = '0;
      debCnt_d = '0;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] != keyDeb_q[i]) begin
            if (debCnt_q[i] == DEB_LAST) begin
               keyDeb_d[i] = sync2_q[i];
               keyEvt_d[i] = ~sync2_q[i];
            end else begin
               debCnt_d[i] = satInc(debCnt_q[i]);
            end
         end
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1_q  <= '1;
         sync2_q  <= '1;
         keyDeb_q <= '1;
         keyEvt_q <= '0;
         debCnt_q <= '0;
      end else begin
         sync1_q  <= keyRaw;
         sync2_q  <= sync1_q;
         keyDeb_q <= keyDeb_d;
         keyEvt_q <= keyEvt_d;
         debCnt_q <= debCnt_d;
      end
   end

   assign reqCold  = keyEvt_q[0] | soft_cold_req;
   assign reqWarm  = keyEvt_q[1] | soft_warm_req;
   assign reqDebug = keyEvt_q[2];
   assign reqAny   = reqCold | reqWarm | reqDebug;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_d     = satInc(cnt_q);
      dropped_d = dropped_q;
      case (state_q)
         ST_STARTUP: begin
            if (reqAny) dropped_d = 1'b1;
            if (cnt_q == POR_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         ST_IDLE: begin
            cnt_d = '0;
            if (reqCold) begin
               sel_d   = SEL_COLD;
               state_d = ST_ASSERT;
               if (reqWarm || reqDebug) dropped_d = 1'b1;
            end else if (reqWarm) begin
               sel_d   = SEL_WARM;
               state_d = ST_ASSERT;
               if (reqDebug) dropped_d = 1'b1;
            end else if (reqDebug) begin
               sel_d   = SEL_DEBUG;
               state_d = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            // Cold preempts a running warm/debug pulse and restarts the width count.
            if (reqCold && sel_q != SEL_COLD) begin
               sel_d = SEL_COLD;
               cnt_d = '0;
               if (reqWarm || reqDebug) dropped_d = 1'b1;
            end else begin
               if (reqAny) dropped_d = 1'b1;
               if (cnt_q == PULSE_LAST) begin
                  state_d = ST_HOLDOFF;
                  cnt_d   = '0;
               end
            end
         end
         ST_HOLDOFF: begin
            if (reqAny) dropped_d = 1'b1;
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_STARTUP;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from next state so they are registered yet switch on the same edge.
   always_comb begin
      coldN_d  = !(state_d == ST_ASSERT && sel_d == SEL_COLD);
      warmN_d  = !(state_d == ST_ASSERT && sel_d == SEL_WARM);
      debugN_d = !(state_d == ST_ASSERT && sel_d == SEL_DEBUG);
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q   <= ST_STARTUP;
         sel_q     <= SEL_COLD;
         cnt_q     <= '0;
         dropped_q <= 1'b0;
         coldN_q   <= 1'b1;
         warmN_q   <= 1'b1;
         debugN_q  <= 1'b1;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         dropped_q <= dropped_d;
         coldN_q   <= coldN_d;
         warmN_q   <= warmN_d;
         debugN_q  <= debugN_d;
         busy_q    <= busy_d;
      end
   end

   assign hps_0_f2h_cold_reset_req_reset_n  = coldN_q;
   assign hps_0_f2h_warm_reset_req_reset_n  = warmN_q;
   assign hps_0_f2h_debug_reset_req_reset_n = debugN_q;
   assign busy                              = busy_q;
   assign dropped                           = dropped_q;

endmodule
